// File: rtl/pwm_duty_decoder.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input,
// decodes the duty step and flags off-nominal periods and stuck levels.
module pwm_duty_decoder #(
    parameter int CNT_W          = 8,
    parameter int NOMINAL_PERIOD = 10,
    parameter int TIMEOUT        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PWM_IN,
    output logic [CNT_W-1:0] HIGH_COUNT,
    output logic [CNT_W-1:0] PERIOD_COUNT,
    output logic [3:0]       DUTY_CYCLE_OUT,
    output logic             MEAS_VALID,
    output logic             PERIOD_ERR,
    output logic             STUCK,
    output logic             STUCK_LEVEL
);

    typedef enum logic [1:0] {S_ACQ, S_HIGH, S_LOW, S_STUCK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] NOM_CNT  = CNT_W'(NOMINAL_PERIOD);
    localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [3:0]       NOM_DUTY = 4'(NOMINAL_PERIOD);

    state_t           state_q;
    logic             s1_q, s2_q, sp_q;
    logic [1:0]       warm_q;
    logic [CNT_W-1:0] hi_q, per_q, idle_q;
    logic [CNT_W-1:0] high_count_q, period_count_q;
    logic [3:0]       duty_q;
    logic             meas_valid_q, period_err_q, stuck_q, stuck_level_q;

    logic             rise, fall, timeout;
    logic [CNT_W-1:0] hi_inc_d, per_inc_d, idle_d;

    always_comb begin
        rise      = s2_q & ~sp_q;
        fall      = ~s2_q & sp_q;
        hi_inc_d  = (hi_q == CNT_MAX) ? hi_q : hi_q + CNT_ONE;
        per_inc_d = (per_q == CNT_MAX) ? per_q : per_q + CNT_ONE;
        if (rise | fall) begin
            idle_d = '0;
        end else begin
            idle_d = (idle_q == CNT_MAX) ? idle_q : idle_q + CNT_ONE;
        end
        timeout = (state_q != S_STUCK) && (idle_d == TMO_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_ACQ;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            sp_q           <= 1'b0;
            warm_q         <= 2'd0;
            hi_q           <= '0;
            per_q          <= '0;
            idle_q         <= '0;
            high_count_q   <= '0;
            period_count_q <= '0;
            duty_q         <= 4'd0;
            meas_valid_q   <= 1'b0;
            period_err_q   <= 1'b0;
            stuck_q        <= 1'b0;
            stuck_level_q  <= 1'b0;
        end else begin
            s1_q         <= PWM_IN;
            s2_q         <= s1_q;
            sp_q         <= s2_q;
            idle_q       <= idle_d;
            meas_valid_q <= 1'b0;
            // The synchronizer holds reset zeros, not samples, for three
            // clocks; a rise seen then is an artefact of reset, not a real edge.
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
            if (timeout) begin
                state_q        <= S_STUCK;
                stuck_q        <= 1'b1;
                stuck_level_q  <= s2_q;
                period_count_q <= '0;
                period_err_q   <= 1'b0;
                high_count_q   <= s2_q ? NOM_CNT : '0;
                duty_q         <= s2_q ? NOM_DUTY : 4'd0;
                meas_valid_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_ACQ: begin
                        if (rise && warm_q == 2'd3) begin
                            state_q <= S_HIGH;
                            per_q   <= CNT_ONE;
                            hi_q    <= CNT_ONE;
                        end
                    end
                    S_HIGH: begin
                        per_q <= per_inc_d;
                        if (fall) begin
                            state_q <= S_LOW;
                        end else begin
                            hi_q <= hi_inc_d;
                        end
                    end
                    S_LOW: begin
                        if (rise) begin
                            state_q        <= S_HIGH;
                            high_count_q   <= hi_q;
                            period_count_q <= per_q;
                            meas_valid_q   <= 1'b1;
                            if (per_q == NOM_CNT) begin
                                duty_q       <= hi_q[3:0];
                                period_err_q <= 1'b0;
                            end else begin
                                period_err_q <= 1'b1;
                            end
                            per_q <= CNT_ONE;
                            hi_q  <= CNT_ONE;
                        end else begin
                            per_q <= per_inc_d;
                        end
                    end
                    S_STUCK: begin
                        if (rise) begin
                            state_q       <= S_HIGH;
                            per_q         <= CNT_ONE;
                            hi_q          <= CNT_ONE;
                            stuck_q       <= 1'b0;
                            stuck_level_q <= 1'b0;
                        end else if (fall) begin
                            state_q       <= S_ACQ;
                            stuck_q       <= 1'b0;
                            stuck_level_q <= 1'b0;
                        end
                    end
                    default: state_q <= S_ACQ;
                endcase
            end
        end
    end

    assign HIGH_COUNT     = high_count_q;
    assign PERIOD_COUNT   = period_count_q;
    assign DUTY_CYCLE_OUT = duty_q;
    assign MEAS_VALID     = meas_valid_q;
    assign PERIOD_ERR     = period_err_q;
    assign STUCK          = stuck_q;
    assign STUCK_LEVEL    = stuck_level_q;

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive-side counterpart of the PWM generator. Samples an incoming PWM waveform on the system clock and measures high time and period in clock cycles.
- Reports the decoded duty step (0–NOMINAL_PERIOD) and flags period mismatches and stuck-level (0%/100%) inputs.
- Used as a loopback checker on PWM_OUT and as a decoder for external PWM inputs.

Parameters:
- CNT_W, 8: width of the high-time, period and idle counters.
- NOMINAL_PERIOD, 10: expected PWM period in clk cycles; must be ≤15.
- TIMEOUT, 32: cycles without an edge before STUCK is declared; must satisfy NOMINAL_PERIOD < TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock (100 MHz); single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- PWM_IN  in  1  PWM input; asynchronous to clk.
- HIGH_COUNT  out  CNT_W  high cycles in the last measured period.
- PERIOD_COUNT  out  CNT_W  total cycles in the last measured period (rise to rise).
- DUTY_CYCLE_OUT  out  4  decoded duty step.
- MEAS_VALID  out  1  1-cycle pulse; all measurement outputs updated this cycle.
- PERIOD_ERR  out  1  level; 1 when the last PERIOD_COUNT ≠ NOMINAL_PERIOD.
- STUCK  out  1  level; input has had no edge for TIMEOUT cycles.
- STUCK_LEVEL  out  1  input level while STUCK=1.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs, counters and sync flops go to 0; FSM goes to ACQ.
  - Applies mid-operation; no partial measurement is ever published.
- Input conditioning:
  - 2-flop synchronizer s1→s2, plus a delay flop sp.
  - rise = s2 & ~sp; fall = ~s2 & sp.
  - No glitch filter: a 1-cycle pulse is a valid high time.
- Counters:
  - hi_cnt, per_cnt and idle_cnt saturate at 2^CNT_W−1.
  - idle_cnt clears on any rise or fall, else increments.
- FSM states: ACQ, HIGH, LOW, STUCK.
- ACQ: ignore input until rise. On rise → HIGH with per_cnt=1, hi_cnt=1.
- HIGH:
  - Each cycle per_cnt+1 and hi_cnt+1.
  - On fall → LOW; per_cnt+1 (first low cycle); hi_cnt holds.
- LOW: each cycle per_cnt+1. On rise:
  - Publish PERIOD_COUNT=per_cnt, HIGH_COUNT=hi_cnt, MEAS_VALID=1.
  - Reload per_cnt=1, hi_cnt=1; → HIGH.
- Resulting counts: HIGH_COUNT is exactly the number of high cycles and PERIOD_COUNT exactly the total cycles. Publication latency is 3 clk after the PWM_IN rise, from synchronizer plus output register.
- Duty decode, registered in the MEAS_VALID cycle:
  - If PERIOD_COUNT == NOMINAL_PERIOD: DUTY_CYCLE_OUT = HIGH_COUNT[3:0] and PERIOD_ERR=0.
  - Else: DUTY_CYCLE_OUT holds its previous value and PERIOD_ERR=1.
- Timeout: when idle_cnt reaches TIMEOUT in any state except STUCK → STUCK. That cycle publishes:
  - STUCK=1, STUCK_LEVEL=s2, PERIOD_COUNT=0, PERIOD_ERR=0.
  - HIGH_COUNT = DUTY_CYCLE_OUT = (s2 ? NOMINAL_PERIOD : 0).
  - One MEAS_VALID pulse; no further pulses while STUCK.
- Leaving STUCK:
  - On rise → HIGH with counters reloaded to 1; STUCK and STUCK_LEVEL clear that cycle.
  - On fall → ACQ; STUCK clears.
  - The first valid period after STUCK needs a complete rise-to-rise.
- Simultaneous events:
  - rise and timeout in the same cycle cannot occur, since an edge clears idle_cnt.
  - Reset overrides everything.
- Outputs other than MEAS_VALID hold their values between measurements.

Test Plan:
- Period 10, high 5, continuous: MEAS_VALID every 10 clk from the second rise; HIGH_COUNT=5, PERIOD_COUNT=10, DUTY_CYCLE_OUT=5, PERIOD_ERR=0.
- Duty stepped 5→7 at a period boundary: next MEAS_VALID gives HIGH_COUNT=7, DUTY_CYCLE_OUT=7; the previous measurement stays 5.
- Period 12, high 4, after a duty-5 lock: PERIOD_COUNT=12, HIGH_COUNT=4, PERIOD_ERR=1, DUTY_CYCLE_OUT stays 5.
- Hold input low 40 clk, then resume period 10/high 3:
  - STUCK=1 and STUCK_LEVEL=0 exactly 32 clk after the last synchronized edge.
  - DUTY_CYCLE_OUT=0; single MEAS_VALID.
  - STUCK clears on the first rise; the next MEAS_VALID is one full period later with HIGH_COUNT=3.
- Hold input high 40 clk: STUCK=1, STUCK_LEVEL=1, HIGH_COUNT=10, DUTY_CYCLE_OUT=10, PERIOD_COUNT=0.
- rst_n low for 1 clk mid-high: all outputs 0 the next cycle; no MEAS_VALID on the following rise; first MEAS_VALID one period after that rise; a 1-cycle high pulse then gives HIGH_COUNT=1.
